// File: rtl/ip_spi_command_slave.sv
// SPI mode-3 command slave: decodes host commands into key-matrix writes,
// banked SDRAM byte writes, CPU reset control and a status readback.
`timescale 1ns/1ps
module ip_spi_command_slave (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_n,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [3:0]  key_y,
  output logic [7:0]  key_x,
  output logic        key_we,
  output logic [22:0] sdram_address,
  output logic [7:0]  sdram_wdata,
  output logic        sdram_wr_req,
  input  logic        sdram_wr_ack,
  input  logic        sdram_busy,
  output logic        cpu_reset,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_CMD, S_KEY_Y, S_KEY_X, S_BANK, S_DATA, S_STATUS, S_HI, S_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cs_sync_q, sck_sync_q, mosi_sync_q;
  logic        cs_prev_q, sck_prev_q;
  logic        cs_s, sck_s, mosi_s;
  logic        sck_rise, sck_fall, cs_fall;
  logic [2:0]  bit_cnt_q;
  logic        byte_vld_q, byte_done;
  logic [7:0]  rx_q, tx_q, tx_load_val;
  logic        tx_load;
  logic [3:0]  key_y_q;
  logic [7:0]  key_x_q, bank_q, wdata_q;
  logic        key_we_q, bank_hi_q, cpu_reset_q, overrun_q;
  logic [13:0] offset_q, offset_d;
  logic        wr_req_q, wr_req_d;
  logic [22:0] addr_q;
  logic        ld_key_y, wr_key, ld_bank, ld_hi, data_byte;
  logic        set_cpu_rst, clr_cpu_rst, wr_issue, wr_drop;

  // Input synchronisers and edge detection on the synchronised copies
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q   <= 2'b11;
      sck_sync_q  <= 2'b11;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      sck_sync_q  <= {sck_sync_q[0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      cs_prev_q   <= cs_sync_q[1];
      sck_prev_q  <= sck_sync_q[1];
    end
  end

  assign cs_s     = cs_sync_q[1];
  assign sck_s    = sck_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;
  assign sck_fall = ~sck_s & sck_prev_q & ~cs_s;
  assign cs_fall  = ~cs_s & cs_prev_q;

  // Receive: bit count is control, shift register is pure data
  always_ff @(posedge clk) begin
    if (reset || cs_s) begin
      bit_cnt_q  <= 3'd0;
      byte_vld_q <= 1'b0;
    end else begin
      byte_vld_q <= sck_rise && (bit_cnt_q == 3'd7);
      if (sck_rise) bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (sck_rise) rx_q <= {rx_q[6:0], mosi_s};
  end

  assign byte_done = byte_vld_q & ~cs_s;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_CMD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = S_CMD;
    end else if (byte_done) begin
      case (state_q)
        S_CMD: begin
          case (rx_q)
            8'h03:   state_d = S_KEY_Y;
            8'h04:   state_d = S_BANK;
            8'h05:   state_d = S_STATUS;
            8'h07:   state_d = S_HI;
            default: state_d = S_IGNORE;
          endcase
        end
        S_KEY_Y:  state_d = S_KEY_X;
        S_BANK:   state_d = S_DATA;
        S_DATA:   state_d = S_DATA;
        default:  state_d = S_IGNORE;
      endcase
    end
  end

  always_comb begin
    ld_key_y    = 1'b0;
    wr_key      = 1'b0;
    ld_bank     = 1'b0;
    ld_hi       = 1'b0;
    data_byte   = 1'b0;
    set_cpu_rst = 1'b0;
    clr_cpu_rst = 1'b0;
    if (byte_done) begin
      case (state_q)
        S_CMD: begin
          clr_cpu_rst = (rx_q == 8'h02);
          set_cpu_rst = (rx_q == 8'h06);
        end
        S_KEY_Y: ld_key_y  = 1'b1;
        S_KEY_X: wr_key    = 1'b1;
        S_BANK:  ld_bank   = 1'b1;
        S_DATA:  data_byte = 1'b1;
        S_HI:    ld_hi     = 1'b1;
        default: ;
      endcase
    end
  end

  // A byte arriving while the previous write is still unacknowledged is lost
  assign wr_issue = data_byte & ~wr_req_q;
  assign wr_drop  = data_byte & wr_req_q;

  always_comb begin
    offset_d = offset_q;
    if (ld_bank)       offset_d = 14'd0;
    else if (wr_issue) offset_d = offset_q + 14'd1;
    wr_req_d = wr_req_q;
    if (wr_issue)          wr_req_d = 1'b1;
    else if (sdram_wr_ack) wr_req_d = 1'b0;
  end

  // The status byte is chosen by the state the just-completed byte leads to
  assign tx_load     = cs_fall | byte_done;
  assign tx_load_val = (state_d == S_STATUS) ? {7'b0, sdram_busy} : 8'hA5;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q <= 8'hFF;
    end else if (tx_load) begin
      tx_q <= tx_load_val;
    end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
      tx_q <= {tx_q[6:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_y_q     <= 4'd0;
      key_x_q     <= 8'hFF;
      key_we_q    <= 1'b0;
      bank_q      <= 8'd0;
      bank_hi_q   <= 1'b0;
      offset_q    <= 14'd0;
      wr_req_q    <= 1'b0;
      addr_q      <= 23'd0;
      wdata_q     <= 8'd0;
      cpu_reset_q <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      key_we_q <= wr_key;
      offset_q <= offset_d;
      wr_req_q <= wr_req_d;
      if (ld_key_y)    key_y_q     <= rx_q[3:0];
      if (wr_key)      key_x_q     <= rx_q;
      if (ld_bank)     bank_q      <= rx_q;
      if (ld_hi)       bank_hi_q   <= rx_q[0];
      if (set_cpu_rst) cpu_reset_q <= 1'b1;
      if (clr_cpu_rst) cpu_reset_q <= 1'b0;
      if (wr_drop)     overrun_q   <= 1'b1;
      if (wr_issue) begin
        addr_q  <= {bank_hi_q, bank_q, offset_q};
        wdata_q <= rx_q;
      end
    end
  end

  assign spi_miso      = tx_q[7];
  assign key_y         = key_y_q;
  assign key_x         = key_x_q;
  assign key_we        = key_we_q;
  assign sdram_address = addr_q;
  assign sdram_wdata   = wdata_q;
  assign sdram_wr_req  = wr_req_q;
  assign cpu_reset     = cpu_reset_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_ip_spi_command_slave.sv
// Bench for ip_spi_command_slave: drives SPI mode-3 transactions and checks
// responses, key strobes and SDRAM writes against a transaction-level model.
`timescale 1ns/1ps
module tb_ip_spi_command_slave;

  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_clk = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [3:0]  key_y;
  logic [7:0]  key_x;
  logic        key_we;
  logic [22:0] sdram_address;
  logic [7:0]  sdram_wdata;
  logic        sdram_wr_req;
  logic        sdram_wr_ack = 1'b0;
  logic        sdram_busy = 1'b0;
  logic        cpu_reset;
  logic        overrun;

  always #5 clk = ~clk;

  ip_spi_command_slave dut (
    .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .key_y(key_y), .key_x(key_x),
    .key_we(key_we), .sdram_address(sdram_address), .sdram_wdata(sdram_wdata),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
    .sdram_busy(sdram_busy), .cpu_reset(cpu_reset), .overrun(overrun)
  );

  int tests = 0;
  int fails = 0;

  // Model state: what the slave must have done, derived from the byte stream
  logic [11:0] kq[$];
  logic [30:0] wq[$];
  logic [7:0]  rx_log[$];
  logic [7:0]  m_cmd, m_resp, m_bank;
  logic [3:0]  m_key_y;
  logic [13:0] m_offset;
  logic        m_hi, m_cpu_reset, m_overrun;
  int          m_idx;
  int          outstanding = 0;
  bit          ack_hold = 1'b0;
  logic [22:0] last_wr_addr = '0;
  logic [7:0]  last_wr_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bank = 8'd0; m_offset = 14'd0; m_hi = 1'b0; m_key_y = 4'd0;
    m_cpu_reset = 1'b1; m_overrun = 1'b0; m_cmd = 8'd0; m_idx = 0; m_resp = 8'hA5;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_clk = 1'b0; spi_mosi = tx[i];
      #HALF;
      rx[i] = spi_miso;
      spi_clk = 1'b1;
      #HALF;
    end
  endtask

  task automatic cs_begin();
    @(negedge clk);
    spi_cs_n = 1'b0;
    m_idx = 0; m_resp = 8'hA5;
    rx_log.delete();
    #(2*HALF);
  endtask

  task automatic cs_end();
    #HALF;
    spi_cs_n = 1'b1;
    #(2*HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] rx, resp_next;
    repeat (4) @(negedge clk);
    resp_next = 8'hA5;
    if (m_idx == 0) begin
      m_cmd = b;
      if (b == 8'h02) m_cpu_reset = 1'b0;
      if (b == 8'h06) m_cpu_reset = 1'b1;
      if (b == 8'h05) resp_next = {7'b0, sdram_busy};
    end else if (m_cmd == 8'h03 && m_idx == 1) begin
      m_key_y = b[3:0];
    end else if (m_cmd == 8'h03 && m_idx == 2) begin
      kq.push_back({m_key_y, b});
    end else if (m_cmd == 8'h04 && m_idx == 1) begin
      m_bank = b; m_offset = 14'd0;
    end else if (m_cmd == 8'h04) begin
      if (outstanding != 0) m_overrun = 1'b1;
      else begin
        wq.push_back({m_hi, m_bank, m_offset, b});
        outstanding = 1;
        m_offset = m_offset + 14'd1;
      end
    end else if (m_cmd == 8'h07 && m_idx == 1) begin
      m_hi = b[0];
    end
    spi_bits(b, 8, rx);
    chk("miso_byte", 32'(rx), 32'(m_resp));
    rx_log.push_back(rx);
    m_resp = resp_next;
    m_idx++;
  endtask

  task automatic xact(input int n, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    cs_begin();
    if (n > 0) send_byte(b0);
    if (n > 1) send_byte(b1);
    if (n > 2) send_byte(b2);
    if (n > 3) send_byte(b3);
    cs_end();
  endtask

  task automatic wait_writes();
    for (int i = 0; i < 300 && wq.size() != 0; i++) @(negedge clk);
    chk("writes_drained", 32'(wq.size()), 32'd0);
  endtask

  task automatic end_checks();
    wait_writes();
    chk("keys_drained", 32'(kq.size()), 32'd0);
    chk("cpu_reset", 32'(cpu_reset), 32'(m_cpu_reset));
    chk("overrun", 32'(overrun), 32'(m_overrun));
  endtask

  // Compare process: acts as the SDRAM acker and checks every strobe/write
  initial begin
    logic [30:0] prev_aw, e;
    bit prev_req, unstable;
    int ack_cnt;
    prev_req = 1'b0; unstable = 1'b0; ack_cnt = 0; prev_aw = '0;
    forever begin
      @(negedge clk);
      sdram_wr_ack = 1'b0;
      if (key_we) begin
        if (kq.size() == 0) begin
          tests++; fails++;
          $display("FAIL key_we_unexpected: got y=%0h x=%0h expected no strobe", key_y, key_x);
        end else begin
          chk("key_event", 32'({key_y, key_x}), 32'(kq.pop_front()));
        end
      end
      if (sdram_wr_req && !reset) begin
        if (prev_req && ({sdram_address, sdram_wdata} != prev_aw)) unstable = 1'b1;
        prev_aw = {sdram_address, sdram_wdata};
        if (!ack_hold) begin
          ack_cnt++;
          if (ack_cnt == 3) begin
            sdram_wr_ack = 1'b1;
            ack_cnt = 0;
            outstanding = 0;
            last_wr_addr = sdram_address;
            last_wr_data = sdram_wdata;
            if (wq.size() == 0) begin
              tests++; fails++;
              $display("FAIL wr_unexpected: got %0h@%0h expected no write", sdram_wdata, sdram_address);
            end else begin
              e = wq.pop_front();
              chk("wr_addr", 32'(sdram_address), 32'(e[30:8]));
              chk("wr_data", 32'(sdram_wdata), 32'(e[7:0]));
            end
            chk("wr_stable", 32'(unstable), 32'd0);
          end
        end
      end else begin
        ack_cnt = 0;
        unstable = 1'b0;
      end
      prev_req = sdram_wr_req;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    model_reset();
    repeat (4) @(negedge clk);
    chk("rst_miso", 32'(spi_miso), 32'd1);
    chk("rst_key_y", 32'(key_y), 32'd0);
    chk("rst_key_x", 32'(key_x), 32'hFF);
    chk("rst_key_we", 32'(key_we), 32'd0);
    chk("rst_wr_req", 32'(sdram_wr_req), 32'd0);
    chk("rst_addr", 32'(sdram_address), 32'd0);
    chk("rst_wdata", 32'(sdram_wdata), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    xact(1, 8'h00, 8'h00, 8'h00, 8'h00);
    end_checks();

    xact(3, 8'h03, 8'h05, 8'h7E, 8'h00);
    end_checks();
    chk("lit_key_y", 32'(key_y), 32'h5);
    chk("lit_key_x", 32'(key_x), 32'h7E);

    sdram_busy = 1'b1;
    xact(2, 8'h05, 8'h00, 8'h00, 8'h00);
    chk("lit_status_busy", 32'(rx_log[1]), 32'h01);
    sdram_busy = 1'b0;
    xact(2, 8'h05, 8'h00, 8'h00, 8'h00);
    chk("lit_status_idle", 32'(rx_log[1]), 32'h00);
    end_checks();

    xact(2, 8'h07, 8'h01, 8'h00, 8'h00);
    xact(4, 8'h04, 8'h02, 8'h11, 8'h22);
    end_checks();
    chk("lit_wr_addr_hi", 32'(last_wr_addr), 32'h408001);
    chk("lit_wr_data_hi", 32'(last_wr_data), 32'h22);
    chk("lit_overrun_clear", 32'(overrun), 32'd0);

    // Offset wrap: jump the offset near the top of the bank, then stream on
    xact(2, 8'h07, 8'h00, 8'h00, 8'h00);
    cs_begin();
    send_byte(8'h04); send_byte(8'h08); send_byte(8'hA0);
    wait_writes();
    @(negedge clk);
    force dut.offset_q = 14'h3FFE;
    @(posedge clk); #1;
    release dut.offset_q;
    m_offset = 14'h3FFE;
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
    cs_end();
    end_checks();
    chk("lit_wrap_addr", 32'(last_wr_addr), 32'h020000);
    chk("lit_wrap_data", 32'(last_wr_data), 32'hB3);

    // Overrun: hold off the ack across two data bytes, release after CS rises
    cs_begin();
    send_byte(8'h04); send_byte(8'h09);
    ack_hold = 1'b1;
    send_byte(8'hC1); send_byte(8'hC2);
    cs_end();
    chk("lit_req_held", 32'(sdram_wr_req), 32'd1);
    ack_hold = 1'b0;
    end_checks();
    chk("lit_overrun_set", 32'(overrun), 32'd1);
    chk("lit_ovr_addr", 32'(last_wr_addr), 32'h024000);
    chk("lit_ovr_data", 32'(last_wr_data), 32'hC1);

    xact(1, 8'h02, 8'h00, 8'h00, 8'h00);
    chk("lit_cpu_run", 32'(cpu_reset), 32'd0);
    xact(1, 8'h06, 8'h00, 8'h00, 8'h00);
    chk("lit_cpu_hold", 32'(cpu_reset), 32'd1);
    xact(1, 8'h02, 8'h00, 8'h00, 8'h00);
    end_checks();

    cs_begin();
    spi_bits(8'h06, 4, rx);
    cs_end();
    xact(3, 8'h03, 8'h0A, 8'h55, 8'h00);
    end_checks();
    chk("lit_partial_cpu", 32'(cpu_reset), 32'd0);

    // Reset in the middle of a byte with a write still pending
    cs_begin();
    send_byte(8'h04); send_byte(8'h0A);
    ack_hold = 1'b1;
    send_byte(8'hD1);
    spi_bits(8'h04, 4, rx);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wq.delete(); outstanding = 0; ack_hold = 1'b0;
    model_reset();
    chk("lit_req_after_reset", 32'(sdram_wr_req), 32'd0);
    cs_end();
    xact(3, 8'h03, 8'h0C, 8'h3C, 8'h00);
    end_checks();
    chk("lit_post_reset_key_x", 32'(key_x), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
